lcd_controller: RTL and testbench
=================================

Name: lcd_controller

Overview:
- Character-write driver for the HD44780-compatible 2x16 LCD on the FPGA board, run over the 4-bit bus SF_D[11:8].
- After reset it performs the power-on initialisation and configuration sequence.
- After that it accepts single-character writes addressed by a 5-bit screen location.
- It sits under the register-display block, which streams characters into it with writeEnable held high.

Parameters:
- T_POWERUP, 750000: idle cycles after reset before the first init nibble (15 ms at 50 MHz).
- T_INIT1, 205000: wait after the first 0x3 init nibble (4.1 ms).
- T_INIT2, 5000: wait after the second 0x3 init nibble (100 us).
- T_CMD, 2000: wait after the third 0x3 nibble, after the 0x2 nibble, and after every full byte (40 us).
- T_CLEAR, 82000: wait after the Clear Display command (1.64 ms).
- T_NIB_GAP, 50: wait between the upper and lower nibble of one byte (1 us).
- T_E_SETUP, 2: cycles SF_D/LCD_RS are stable before LCD_E rises.
- T_E_HIGH, 12: cycles LCD_E stays high.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- writeEnable  in  1  request to write one character; sampled only while idle
- location  in  5  screen position; [4] selects the row, [3:0] the column
- data  in  8  ASCII character to write
- SF_D  out  4  LCD data nibble (board SF_D[11:8])
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  register select: 0 = command, 1 = data
- LCD_RW  out  1  read/write; tied to 0 (write only)
- busy  out  1  high while initialising or executing a write

Behaviour:
- Reset (synchronous, active-high):
  - SF_D=0, LCD_E=0, LCD_RS=0, LCD_RW=0, busy=1.
  - The sequencer restarts at the power-up wait.
  - Asserting reset mid-operation aborts at the next clock edge; no partial strobe continues.
- LCD_RW is 0 in every cycle.
- Nibble strobe:
  - Drive SF_D and LCD_RS.
  - After T_E_SETUP cycles, raise LCD_E for T_E_HIGH cycles, then drop it.
  - SF_D/LCD_RS stay stable until at least 1 cycle after LCD_E falls.
- Byte transfer:
  - Upper nibble strobe, T_NIB_GAP wait, lower nibble strobe (same LCD_RS for both).
  - Then the post-byte wait: T_CMD, or T_CLEAR for command 0x01.
- Init states, in order, all with LCD_RS=0:
  - POWERUP: wait T_POWERUP.
  - Nibble 0x3, wait T_INIT1.
  - Nibble 0x3, wait T_INIT2.
  - Nibble 0x3, wait T_CMD.
  - Nibble 0x2, wait T_CMD.
  - Bytes: 0x28 function set (4-bit, 2 lines), 0x06 entry mode (increment, no shift), 0x0C display on (cursor off), 0x01 clear (wait T_CLEAR).
  - Then IDLE, busy=0.
- IDLE:
  - If writeEnable=1, in the same edge latch location and data, set busy=1 and start the write.
  - Later changes to location, data or writeEnable are ignored until busy returns to 0.
- Write sequence:
  - Set-DDRAM-address command with LCD_RS=0. Byte = 0x80 | (location[4] ? 0x40 : 0x00) | location[3:0]. Location 5 gives 0x85; location 16 gives 0xC0; location 27 gives 0xCB.
  - Then the data byte with LCD_RS=1, followed by a T_CMD wait.
  - Then return to IDLE with busy=0.
- With writeEnable held high continuously, the next write starts on the first IDLE cycle and uses the location/data present on that cycle. Writes whose values are not sampled are dropped, not queued.
- writeEnable during init or during a write is ignored; there is no error indication.
- All counters are wide enough for the largest parameter. Waits are exact cycle counts with ±1 cycle tolerance.
- Outside strobes, LCD_E=0; SF_D holds its last value.

Test Plan:
- Set all T_* to small values (e.g. 20/10/5/4/3/8/1/2). Apply reset for 2 cycles, then release -> outputs at reset values; busy=1. Nibbles 3,3,3,2 then bytes 28,06,0C,01 appear on SF_D at LCD_E rising edges, all with LCD_RS=0, spaced per the parameters. busy falls after the clear wait.
- After init, pulse writeEnable for 1 cycle with location=5, data=0x41 -> strobes 0x8,0x5 with RS=0, then 0x4,0x1 with RS=1. busy=1 for the whole sequence, then 0.
- Write with location=27, data=0x46 -> address nibbles 0xC,0xB, then data nibbles 0x4,0x6.
- Hold writeEnable=1 and change location/data every cycle -> each write uses exactly the values present on its start cycle. No strobe patterns overlap. LCD_RW=0 throughout.
- Pulse writeEnable during init -> it is ignored. The init sequence is unchanged and no data strobe occurs.
- Assert reset in the middle of a data nibble while LCD_E=1 -> next cycle LCD_E=0, SF_D=0, busy=1. The full init sequence restarts.

Source files
------------

// File: rtl/lcd_controller.sv
// rtl/lcd_controller.sv - HD44780 4-bit character-write driver with power-on init sequencer
// Steps 0-11 form the init list, steps 12-15 one character write (address byte, data byte).
module lcd_controller #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_NIB_GAP = 50,
  parameter int T_E_SETUP = 2,
  parameter int T_E_HIGH  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeEnable,
  input  logic [4:0] location,
  input  logic [7:0] data,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       busy
);

  localparam int CW = $clog2(T_POWERUP + T_INIT1 + T_INIT2 + T_CMD + T_CLEAR +
                             T_NIB_GAP + T_E_SETUP + T_E_HIGH + 1);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_EHIGH,
    ST_WAIT,
    ST_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, limit;
  logic          done;
  logic [3:0]    step_q, step_d;
  logic [4:0]    loc_q, loc_d;
  logic [7:0]    dat_q, dat_d;
  logic [3:0]    sf_d_q, sf_d_d;
  logic          rs_q, rs_d;

  // Returns {rs, nibble} for a sequencer step.
  function automatic logic [4:0] nibble_for(input logic [3:0] step, input logic [4:0] loc,
                                            input logic [7:0] dat);
    logic [7:0] addr;
    addr = {1'b1, loc[4], 2'b00, loc[3:0]};
    case (step)
      4'd0, 4'd1, 4'd2: nibble_for = {1'b0, 4'h3};
      4'd3, 4'd4:       nibble_for = {1'b0, 4'h2};
      4'd5:             nibble_for = {1'b0, 4'h8};
      4'd6, 4'd8, 4'd10: nibble_for = {1'b0, 4'h0};
      4'd7:             nibble_for = {1'b0, 4'h6};
      4'd9:             nibble_for = {1'b0, 4'hC};
      4'd11:            nibble_for = {1'b0, 4'h1};
      4'd12:            nibble_for = {1'b0, addr[7:4]};
      4'd13:            nibble_for = {1'b0, addr[3:0]};
      4'd14:            nibble_for = {1'b1, dat[7:4]};
      default:          nibble_for = {1'b1, dat[3:0]};
    endcase
  endfunction

  // Wait that follows the strobe of a given step.
  function automatic logic [CW-1:0] wait_for(input logic [3:0] step);
    case (step)
      4'd0:                                   wait_for = CW'(T_INIT1);
      4'd1:                                   wait_for = CW'(T_INIT2);
      4'd11:                                  wait_for = CW'(T_CLEAR);
      4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14: wait_for = CW'(T_NIB_GAP);
      default:                                wait_for = CW'(T_CMD);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_POWERUP;
      cnt_q   <= '0;
      step_q  <= '0;
      loc_q   <= '0;
      dat_q   <= '0;
      sf_d_q  <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      loc_q   <= loc_d;
      dat_q   <= dat_d;
      sf_d_q  <= sf_d_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    limit = '0;
    case (state_q)
      ST_POWERUP: limit = CW'(T_POWERUP);
      ST_SETUP:   limit = CW'(T_E_SETUP);
      ST_EHIGH:   limit = CW'(T_E_HIGH);
      ST_WAIT:    limit = wait_for(step_q);
      default:    limit = '0;
    endcase
    done = (cnt_q == limit - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    step_d  = step_q;
    loc_d   = loc_q;
    dat_d   = dat_q;
    sf_d_d  = sf_d_q;
    rs_d    = rs_q;
    case (state_q)
      ST_POWERUP: begin
        if (done) begin
          state_d          = ST_SETUP;
          cnt_d            = '0;
          step_d           = 4'd0;
          {rs_d, sf_d_d}   = nibble_for(4'd0, loc_q, dat_q);
        end
      end
      ST_SETUP: begin
        if (done) begin
          state_d = ST_EHIGH;
          cnt_d   = '0;
        end
      end
      ST_EHIGH: begin
        if (done) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (done) begin
          cnt_d = '0;
          if (step_q == 4'd11 || step_q == 4'd15) begin
            state_d = ST_IDLE;
          end else begin
            state_d        = ST_SETUP;
            step_d         = step_q + 4'd1;
            {rs_d, sf_d_d} = nibble_for(step_q + 4'd1, loc_q, dat_q);
          end
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (writeEnable) begin
          state_d        = ST_SETUP;
          step_d         = 4'd12;
          loc_d          = location;
          dat_d          = data;
          {rs_d, sf_d_d} = nibble_for(4'd12, location, data);
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    SF_D   = sf_d_q;
    LCD_RS = rs_q;
    LCD_E  = (state_q == ST_EHIGH);
    LCD_RW = 1'b0;
    busy   = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_lcd_controller.sv
// tb/tb_lcd_controller.sv - directed self-checking bench for lcd_controller
module tb_lcd_controller;

  localparam int P = 20, I1 = 10, I2 = 6, C = 4, CL = 9, G = 3, S = 2, H = 3;
  localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                            4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
  localparam int INIT_WAITS [12] = '{I1, I2, C, C, G, C, G, C, G, C, G, CL};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic [4:0] loc = '0;
  logic [7:0] dat = '0;
  logic [3:0] sf;
  logic       e, rs, rw, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_t = 0;

  typedef struct {
    logic [3:0] nib;
    logic       rs;
    logic       busy;
    int         t;
  } strobe_t;

  strobe_t    sq[$];
  strobe_t    mon_s;
  logic       e_prev = 1'b0;
  int         e_width = 0;
  int         bad_width = 0, bad_stable = 0, bad_rw = 0;
  logic [3:0] hold_sf = '0;
  logic       hold_rs = 1'b0;

  lcd_controller #(
    .T_POWERUP(P), .T_INIT1(I1), .T_INIT2(I2), .T_CMD(C),
    .T_CLEAR(CL), .T_NIB_GAP(G), .T_E_SETUP(S), .T_E_HIGH(H)
  ) dut (
    .clk(clk), .reset(reset), .writeEnable(we), .location(loc), .data(dat),
    .SF_D(sf), .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder plus bus-protocol watchers, sampled on the falling edge.
  always @(negedge clk) begin
    if (rw !== 1'b0) bad_rw++;
    if (reset) begin
      e_prev  = 1'b0;
      e_width = 0;
    end else begin
      if (e === 1'b1 && !e_prev) begin
        mon_s.nib  = sf;
        mon_s.rs   = rs;
        mon_s.busy = busy;
        mon_s.t    = cyc;
        sq.push_back(mon_s);
        hold_sf = sf;
        hold_rs = rs;
        e_width = 0;
      end
      if (e === 1'b1 || e_prev) begin
        if (sf !== hold_sf || rs !== hold_rs) bad_stable++;
      end
      if (e === 1'b1) e_width++;
      if (e !== 1'b1 && e_prev) begin
        if (e_width < H - 1 || e_width > H + 1) bad_width++;
      end
      e_prev = (e === 1'b1);
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      n_fail++;
      $error("FAIL %s: observed cycle %0d expected %0d (+/-1)", tag, obs, exp);
    end
  endtask

  task automatic exp_strobe(input string tag, input logic [3:0] nib, input logic r, input int exp_t);
    strobe_t s;
    int k;
    k = 0;
    while (sq.size() == 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    assert (sq.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed no strobe expected nibble %0h", tag, nib);
    end
    if (sq.size() != 0) begin
      s = sq.pop_front();
      chk_val({tag, "_nib"}, 32'(s.nib), 32'(nib));
      chk_val({tag, "_rs"}, 32'(s.rs), 32'(r));
      chk_val({tag, "_busy"}, 32'(s.busy), 32'd1);
      if (exp_t >= 0) chk_tol({tag, "_t"}, s.t, exp_t);
      last_t = s.t;
    end
  endtask

  task automatic wait_idle(input string tag, output int t);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    assert (busy === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed busy %b expected 0", tag, busy);
    end
    t = cyc;
  endtask

  task automatic check_init(input int c0);
    int t;
    t = c0 + P + S;
    for (int i = 0; i < 12; i++) begin
      exp_strobe($sformatf("init%0d", i), INIT_NIBS[i], 1'b0, t);
      t = last_t + H + INIT_WAITS[i] + S;
    end
    wait_idle("init_idle", t);
    chk_tol("init_busy_fall", t, last_t + H + CL);
  endtask

  task automatic do_write(input string tag, input logic [4:0] l, input logic [7:0] d,
                          input logic [7:0] addr);
    int k0, t;
    loc = l;
    dat = d;
    we  = 1'b1;
    k0  = cyc;
    @(negedge clk);
    we  = 1'b0;
    loc = ~l;
    dat = ~d;
    chk_val({tag, "_busy_start"}, 32'(busy), 32'd1);
    exp_strobe({tag, "_a_hi"}, addr[7:4], 1'b0, k0 + 1 + S);
    exp_strobe({tag, "_a_lo"}, addr[3:0], 1'b0, last_t + H + G + S);
    exp_strobe({tag, "_d_hi"}, d[7:4], 1'b1, last_t + H + C + S);
    exp_strobe({tag, "_d_lo"}, d[3:0], 1'b1, last_t + H + G + S);
    wait_idle(tag, t);
    chk_tol({tag, "_busy_fall"}, t, last_t + H + C);
  endtask

  initial begin
    int c0, t, k;
    logic [4:0] el[$];
    logic [7:0] ed[$];
    logic [7:0] a;

    @(negedge clk);
    @(negedge clk);
    chk_val("rst_sf", 32'(sf), 32'h0);
    chk_val("rst_e", 32'(e), 32'h0);
    chk_val("rst_rs", 32'(rs), 32'h0);
    chk_val("rst_rw", 32'(rw), 32'h0);
    chk_val("rst_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    c0 = cyc;

    // writeEnable pulse during the power-up wait must be ignored
    repeat (5) @(negedge clk);
    loc = 5'd3;
    dat = 8'h55;
    we  = 1'b1;
    @(negedge clk);
    we  = 1'b0;
    check_init(c0);

    do_write("w5", 5'd5, 8'h41, 8'h85);
    do_write("w27", 5'd27, 8'h46, 8'hCB);
    do_write("w16", 5'd16, 8'h30, 8'hC0);

    // writeEnable held high with inputs changing every cycle
    for (int i = 0; i < 110; i++) begin
      loc = 5'($urandom_range(0, 31));
      dat = 8'($urandom_range(32, 126));
      we  = 1'b1;
      if (busy === 1'b0) begin
        el.push_back(loc);
        ed.push_back(dat);
      end
      @(negedge clk);
    end
    we = 1'b0;
    wait_idle("hold_idle", t);
    for (int i = 0; i < el.size(); i++) begin
      a = {1'b1, el[i][4], 2'b00, el[i][3:0]};
      exp_strobe($sformatf("hold%0d_a_hi", i), a[7:4], 1'b0, -1);
      exp_strobe($sformatf("hold%0d_a_lo", i), a[3:0], 1'b0, -1);
      exp_strobe($sformatf("hold%0d_d_hi", i), ed[i][7:4], 1'b1, -1);
      exp_strobe($sformatf("hold%0d_d_lo", i), ed[i][3:0], 1'b1, -1);
    end
    chk_val("hold_extra_strobes", 32'(sq.size()), 32'd0);

    // reset while a data nibble strobe is high
    loc = 5'd10;
    dat = 8'h5A;
    we  = 1'b1;
    @(negedge clk);
    we = 1'b0;
    k = 0;
    while (!(e === 1'b1 && rs === 1'b1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk_val("mid_data_strobe_seen", 32'(e & rs), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_val("midrst_e", 32'(e), 32'h0);
    chk_val("midrst_sf", 32'(sf), 32'h0);
    chk_val("midrst_busy", 32'(busy), 32'h1);
    chk_val("midrst_rs", 32'(rs), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    sq.delete();
    check_init(c0);

    chk_val("e_width_violations", 32'(bad_width), 32'd0);
    chk_val("bus_stability_violations", 32'(bad_stable), 32'd0);
    chk_val("rw_nonzero_cycles", 32'(bad_rw), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
